// File: rtl/card_dealer.sv
// Deals cards without replacement from one deck, using an xorshift32 RNG stream with
// rejection sampling and a bounded-retry fallback scan. Includes the stateless rng block.

module rng (
    input  logic [31:0] current,
    output logic [31:0] next
);
    logic [31:0] s1;
    logic [31:0] s2;

    // xorshift32 (13, 17, 5); maps any nonzero state to a nonzero state
    always_comb begin
        s1   = current ^ (current << 13);
        s2   = s1 ^ (s1 >> 17);
        next = s2 ^ (s2 << 5);
    end
endmodule

module card_dealer #(
    parameter logic [31:0] SEED      = 32'd1,
    parameter int unsigned DECK_SIZE = 52,
    parameter int unsigned MAX_TRIES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_deck,
    input  logic       draw_req,
    input  logic       card_ack,
    output logic       card_valid,
    output logic [5:0] card,
    output logic [3:0] rank,
    output logic [1:0] suit,
    output logic [5:0] cards_left,
    output logic       deck_empty,
    output logic       busy,
    output logic       draw_err
);
    localparam int unsigned CW = 6;
    localparam int unsigned TW = $clog2(MAX_TRIES + 1);

    typedef enum logic [1:0] {IDLE, DRAW, SCAN, OUT} state_t;

    state_t              state;
    logic [31:0]         rng_state;
    logic [31:0]         rng_next;
    logic [DECK_SIZE-1:0] mask;
    logic [TW-1:0]       tries;
    logic [CW-1:0]       cand;
    logic [CW-1:0]       free_idx;
    logic [CW-1:0]       pick;

    rng u_rng (
        .current (rng_state),
        .next    (rng_next)
    );

    assign cand       = CW'(rng_next % 32'(DECK_SIZE));
    assign pick       = (state == SCAN) ? free_idx : cand;
    assign deck_empty = (cards_left == '0);

    // Lowest-numbered card still in the deck
    always_comb begin
        free_idx = '0;
        for (int i = DECK_SIZE - 1; i >= 0; i--) begin
            if (!mask[i]) begin
                free_idx = CW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rng_state  <= SEED;
            mask       <= '0;
            tries      <= '0;
            card       <= '0;
            rank       <= 4'd1;
            suit       <= '0;
            card_valid <= 1'b0;
            busy       <= 1'b0;
            draw_err   <= 1'b0;
            cards_left <= CW'(DECK_SIZE);
        end else begin
            rng_state <= rng_next;
            draw_err  <= 1'b0;
            if (new_deck) begin
                // Abandons any draw or undelivered card
                mask       <= '0;
                cards_left <= CW'(DECK_SIZE);
                tries      <= '0;
                card_valid <= 1'b0;
                busy       <= 1'b0;
                state      <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (draw_req) begin
                            if (deck_empty) begin
                                draw_err <= 1'b1;
                            end else begin
                                tries <= '0;
                                busy  <= 1'b1;
                                state <= DRAW;
                            end
                        end
                    end
                    DRAW, SCAN: begin
                        if (state == SCAN || !mask[cand]) begin
                            mask[pick] <= 1'b1;
                            card       <= pick;
                            rank       <= 4'(pick % CW'(13)) + 4'd1;
                            suit       <= 2'(pick / CW'(13));
                            cards_left <= cards_left - CW'(1);
                            card_valid <= 1'b1;
                            busy       <= 1'b0;
                            state      <= OUT;
                        end else begin
                            tries <= tries + TW'(1);
                            if (tries == TW'(MAX_TRIES - 1)) begin
                                state <= SCAN;
                            end
                        end
                    end
                    OUT: begin
                        if (card_ack) begin
                            card_valid <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
